// File: rtl/dbs_lock_sequencer.sv
// rtl/dbs_lock_sequencer.sv - clear/ramp/lock sequencer for one DBS filter (on/hold/ND/NF/NG).
// Optional DBS_SEQ_AUTORETRY_EN: timed re-arm from FAULT, up to 3 retries.
module dbs_lock_sequencer #(
  parameter int SIGNAL_SIZE = 25,
  parameter int ARM_CYCLES  = 4,
  parameter int STEP_CYCLES = 1024,
  parameter int RAIL_CYCLES = 4096,
  parameter int CNT_W       = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic                          hold_req,
  input  logic signed [9:0]             ND_start,
  input  logic signed [9:0]             ND_tgt,
  input  logic signed [9:0]             NF_tgt,
  input  logic signed [9:0]             NG_tgt,
  input  logic signed [SIGNAL_SIZE-1:0] LL,
  input  logic signed [SIGNAL_SIZE-1:0] UL,
  input  logic signed [SIGNAL_SIZE-1:0] s_out,
  output logic                          on,
  output logic                          hold,
  output logic signed [9:0]             ND,
  output logic signed [9:0]             NF,
  output logic signed [9:0]             NG,
  output logic                          locked,
  output logic                          fault,
  output logic [2:0]                    state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARM    = 3'd1,
    S_RAMP   = 3'd2,
    S_LOCKED = 3'd3,
    S_FAULT  = 3'd4
  } st_t;

  localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
  localparam logic [CNT_W-1:0] ARM_N     = CNT_W'(ARM_CYCLES);
  localparam logic [CNT_W-1:0] STEP_LAST = CNT_W'(STEP_CYCLES - 1);
  localparam logic [CNT_W-1:0] RAIL_LAST = CNT_W'(RAIL_CYCLES - 1);
`ifdef DBS_SEQ_AUTORETRY_EN
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(8 * ARM_CYCLES - 1);
  logic [3:0] retry_cnt;
`endif

  st_t              st;
  logic [CNT_W-1:0] cnt;       // ARM dwell, RAMP step spacing, FAULT retry wait
  logic [CNT_W-1:0] rail_cnt;
  logic             railed;
  logic             rail_trip;
  logic signed [9:0] nd_step;

  assign state     = st;
  assign railed    = (s_out >= UL) || (s_out <= LL);
  assign rail_trip = !hold && railed && (rail_cnt == RAIL_LAST);
  assign nd_step   = (ND < ND_tgt) ? ND + 10'sd1 : ND - 10'sd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st       <= S_IDLE;
      on       <= 1'b0;
      hold     <= 1'b0;
      locked   <= 1'b0;
      fault    <= 1'b0;
      ND       <= '0;
      NF       <= '0;
      NG       <= '0;
      cnt      <= '0;
      rail_cnt <= '0;
`ifdef DBS_SEQ_AUTORETRY_EN
      retry_cnt <= '0;
`endif
    end else if (!enable) begin
      st       <= S_IDLE;
      on       <= 1'b0;
      hold     <= 1'b0;
      locked   <= 1'b0;
      fault    <= 1'b0;
      cnt      <= '0;
      rail_cnt <= '0;
`ifdef DBS_SEQ_AUTORETRY_EN
      retry_cnt <= '0;
`endif
    end else begin
      case (st)
        S_IDLE: begin
          st       <= S_ARM;
          ND       <= ND_start;
          NF       <= NF_tgt;
          NG       <= NG_tgt;
          cnt      <= '0;
          rail_cnt <= '0;
        end
        S_ARM: begin
          if (cnt == ARM_N) begin
            st  <= S_RAMP;
            on  <= 1'b1;
            cnt <= '0;
          end else begin
            cnt <= cnt + ONE;
          end
        end
        S_RAMP, S_LOCKED: begin
          hold <= hold_req;
          // A rail trip wins over any ND step or lock decision this cycle.
          if (rail_trip) begin
            st       <= S_FAULT;
            on       <= 1'b0;
            hold     <= 1'b0;
            locked   <= 1'b0;
            fault    <= 1'b1;
            cnt      <= '0;
            rail_cnt <= '0;
          end else begin
            if (!hold)
              rail_cnt <= railed ? rail_cnt + ONE : '0;
            if (st == S_LOCKED) begin
              if (ND != ND_tgt) begin
                st     <= S_RAMP;
                locked <= 1'b0;
                cnt    <= '0;
              end
            end else if (ND == ND_tgt) begin
              st     <= S_LOCKED;
              locked <= 1'b1;
              cnt    <= '0;
`ifdef DBS_SEQ_AUTORETRY_EN
              retry_cnt <= '0;
`endif
            end else if (!hold) begin
              if (cnt == STEP_LAST) begin
                cnt <= '0;
                ND  <= nd_step;
                if (nd_step == ND_tgt) begin
                  st     <= S_LOCKED;
                  locked <= 1'b1;
`ifdef DBS_SEQ_AUTORETRY_EN
                  retry_cnt <= '0;
`endif
                end
              end else begin
                cnt <= cnt + ONE;
              end
            end
          end
        end
        S_FAULT: begin
`ifdef DBS_SEQ_AUTORETRY_EN
          if (retry_cnt < 4'd3) begin
            if (cnt == WAIT_LAST) begin
              st        <= S_ARM;
              fault     <= 1'b0;
              ND        <= ND_start;
              NF        <= NF_tgt;
              NG        <= NG_tgt;
              cnt       <= '0;
              rail_cnt  <= '0;
              retry_cnt <= retry_cnt + 4'd1;
            end else begin
              cnt <= cnt + ONE;
            end
          end
`endif
        end
        default: st <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dbs_lock_sequencer.sv
// tb/tb_dbs_lock_sequencer.sv - directed-vector bench for dbs_lock_sequencer.
// Built with ARM_CYCLES=4, STEP_CYCLES=16, RAIL_CYCLES=8.
module tb_dbs_lock_sequencer;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               enable;
  logic               hold_req;
  logic signed [9:0]  ND_start, ND_tgt, NF_tgt, NG_tgt;
  logic signed [24:0] LL, UL, s_out;
  logic               on, hold, locked, fault;
  logic signed [9:0]  ND, NF, NG;
  logic [2:0]         state;

  int vecs = 0;
  int errs = 0;

  dbs_lock_sequencer #(
    .SIGNAL_SIZE(25), .ARM_CYCLES(4), .STEP_CYCLES(16), .RAIL_CYCLES(8), .CNT_W(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .hold_req(hold_req),
    .ND_start(ND_start), .ND_tgt(ND_tgt), .NF_tgt(NF_tgt), .NG_tgt(NG_tgt),
    .LL(LL), .UL(UL), .s_out(s_out),
    .on(on), .hold(hold), .ND(ND), .NF(NF), .NG(NG),
    .locked(locked), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0; enable = 1'b1; hold_req = 1'b0;
    ND_start = -10'sd8; ND_tgt = -10'sd4; NF_tgt = 10'sd33; NG_tgt = -10'sd7;
    LL = -25'sd1000; UL = 25'sd1000; s_out = '0;
    tick(3);
    vecs++; if (state !== 3'd0) begin errs++; $display("FAIL reset_state got %0d want 0", state); end
    vecs++; if ({on, hold, locked, fault} !== 4'b0) begin errs++; $display("FAIL reset_flags got %b want 0000", {on, hold, locked, fault}); end
    vecs++; if ({ND, NF, NG} !== 30'b0) begin errs++; $display("FAIL reset_codes got %0d/%0d/%0d want 0/0/0", ND, NF, NG); end
    rst_n = 1'b1;
  endtask

  task automatic test_arm;
    tick(1);
    vecs++; if (state !== 3'd1) begin errs++; $display("FAIL arm_entry state got %0d want 1", state); end
    vecs++; if (NF !== 10'sd33 || NG !== -10'sd7 || ND !== -10'sd8) begin errs++; $display("FAIL arm_latch got %0d/%0d/%0d want 33/-7/-8", NF, NG, ND); end
    for (int i = 1; i <= 4; i++) begin
      tick(1);
      vecs++; if (on !== 1'b0) begin errs++; $display("FAIL arm_off edge %0d got on=%b want 0", i, on); end
    end
    tick(1);
    vecs++; if (on !== 1'b1 || state !== 3'd2) begin errs++; $display("FAIL arm_exit got on=%b state=%0d want on=1 state=2", on, state); end
  endtask

  task automatic test_ramp;
    for (int k = 1; k <= 4; k++) begin
      tick(15);
      vecs++; if (ND !== 10'(-8 + k - 1)) begin errs++; $display("FAIL ramp_pre step %0d got %0d want %0d", k, ND, -8 + k - 1); end
      tick(1);
      vecs++; if (ND !== 10'(-8 + k)) begin errs++; $display("FAIL ramp_step %0d got %0d want %0d", k, ND, -8 + k); end
      vecs++; if (locked !== (k == 4)) begin errs++; $display("FAIL ramp_locked step %0d got %b want %b", k, locked, k == 4); end
    end
    vecs++; if (state !== 3'd3) begin errs++; $display("FAIL ramp_state got %0d want 3", state); end
  endtask

  task automatic test_retarget;
    ND_tgt = -10'sd6;
    tick(1);
    vecs++; if (locked !== 1'b0 || state !== 3'd2) begin errs++; $display("FAIL retarget_unlock got locked=%b state=%0d want 0/2", locked, state); end
    tick(16);
    vecs++; if (ND !== -10'sd5 || locked !== 1'b0) begin errs++; $display("FAIL retarget_step1 got ND=%0d locked=%b want -5/0", ND, locked); end
    tick(16);
    vecs++; if (ND !== -10'sd6 || locked !== 1'b1) begin errs++; $display("FAIL retarget_step2 got ND=%0d locked=%b want -6/1", ND, locked); end
  endtask

  task automatic test_hold;
    ND_tgt = -10'sd8;
    tick(1);
    tick(6);
    hold_req = 1'b1;
    tick(1);
    vecs++; if (hold !== 1'b1) begin errs++; $display("FAIL hold_assert got %b want 1", hold); end
    tick(39);
    vecs++; if (hold !== 1'b1 || ND !== -10'sd6) begin errs++; $display("FAIL hold_frozen got hold=%b ND=%0d want 1/-6", hold, ND); end
    hold_req = 1'b0;
    tick(9);
    vecs++; if (hold !== 1'b0 || ND !== -10'sd6) begin errs++; $display("FAIL hold_resume_pre got hold=%b ND=%0d want 0/-6", hold, ND); end
    tick(1);
    vecs++; if (ND !== -10'sd7) begin errs++; $display("FAIL hold_resume_step got %0d want -7", ND); end
    tick(16);
    vecs++; if (ND !== -10'sd8 || locked !== 1'b1) begin errs++; $display("FAIL hold_lock got ND=%0d locked=%b want -8/1", ND, locked); end
  endtask

  task automatic test_rail;
    s_out = 25'sd1000;
    tick(7);
    s_out = 25'sd0;
    tick(1);
    vecs++; if (fault !== 1'b0 || on !== 1'b1) begin errs++; $display("FAIL rail_short got fault=%b on=%b want 0/1", fault, on); end
    s_out = -25'sd1000;
    tick(7);
    vecs++; if (fault !== 1'b0 || on !== 1'b1) begin errs++; $display("FAIL rail_prefault got fault=%b on=%b want 0/1", fault, on); end
    tick(1);
    vecs++; if (fault !== 1'b1 || on !== 1'b0 || locked !== 1'b0 || state !== 3'd4) begin errs++; $display("FAIL rail_fault got fault=%b on=%b locked=%b state=%0d want 1/0/0/4", fault, on, locked, state); end
  endtask

`ifdef DBS_SEQ_AUTORETRY_EN
  task automatic test_retry;
    ND_tgt = -10'sd4;
    for (int r = 1; r <= 3; r++) begin
      tick(32);
      vecs++; if (state !== 3'd1 || fault !== 1'b0) begin errs++; $display("FAIL retry_arm %0d got state=%0d fault=%b want 1/0", r, state, fault); end
      tick(5);
      vecs++; if (state !== 3'd2) begin errs++; $display("FAIL retry_ramp %0d got %0d want 2", r, state); end
      tick(8);
      vecs++; if (state !== 3'd4 || fault !== 1'b1) begin errs++; $display("FAIL retry_fault %0d got state=%0d fault=%b want 4/1", r, state, fault); end
    end
    tick(60);
    vecs++; if (state !== 3'd4 || fault !== 1'b1) begin errs++; $display("FAIL retry_exhausted got state=%0d fault=%b want 4/1", state, fault); end
    s_out = '0;
  endtask
`else
  task automatic test_fault_sticky;
    s_out = '0;
    tick(60);
    vecs++; if (state !== 3'd4 || fault !== 1'b1 || on !== 1'b0) begin errs++; $display("FAIL fault_sticky got state=%0d fault=%b on=%b want 4/1/0", state, fault, on); end
  endtask
`endif

  task automatic test_reenable;
    enable = 1'b0;
    ND_start = -10'sd5; ND_tgt = -10'sd5; NF_tgt = 10'sd12;
    tick(1);
    vecs++; if (state !== 3'd0 || fault !== 1'b0 || on !== 1'b0) begin errs++; $display("FAIL disable got state=%0d fault=%b on=%b want 0/0/0", state, fault, on); end
    enable = 1'b1;
    tick(1);
    vecs++; if (state !== 3'd1 || ND !== -10'sd5 || NF !== 10'sd12) begin errs++; $display("FAIL rearm got state=%0d ND=%0d NF=%0d want 1/-5/12", state, ND, NF); end
    tick(4);
    vecs++; if (on !== 1'b0) begin errs++; $display("FAIL rearm_off got on=%b want 0", on); end
    tick(1);
    vecs++; if (on !== 1'b1 || state !== 3'd2) begin errs++; $display("FAIL rearm_on got on=%b state=%0d want 1/2", on, state); end
    tick(1);
    vecs++; if (state !== 3'd3 || locked !== 1'b1) begin errs++; $display("FAIL entry_lock got state=%0d locked=%b want 3/1", state, locked); end
  endtask

  initial begin
    test_reset();
    test_arm();
    test_ramp();
    test_retarget();
    test_hold();
    test_rail();
`ifdef DBS_SEQ_AUTORETRY_EN
    test_retry();
`else
    test_fault_sticky();
`endif
    test_reenable();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
